// File: rtl/xo_board_ctrl.sv
// Tic-tac-toe board controller: button-driven cursor, place/check/win/draw
// sequencing, and a one-cycle registered pixel lookup for the renderer.
module xo_board_ctrl #(
    parameter int BOARD_X = 80,
    parameter int BOARD_Y = 60,
    parameter int CELL_W  = 160,
    parameter int CELL_H  = 120,
    parameter int CUR_T   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_place,
    input  logic       btn_restart,
    input  logic [9:0] scan_x,
    input  logic [8:0] scan_y,
    output logic [9:0] cell_x,
    output logic [8:0] cell_y,
    output logic [1:0] cell_mark,
    output logic       in_board,
    output logic       cursor_hit,
    output logic       turn,
    output logic [1:0] game_state,
    output logic [1:0] winner,
    output logic [7:0] win_line
);

    // state | meaning
    // PLAY  | accepting cursor moves and place
    // CHECK | one cycle: evaluate lines on the freshly written board
    // WIN   | a line was completed; only restart is honoured
    // DRAW  | board full with no line; only restart is honoured
    typedef enum logic [1:0] {
        ST_PLAY  = 2'b00,
        ST_CHECK = 2'b01,
        ST_WIN   = 2'b10,
        ST_DRAW  = 2'b11
    } state_t;

    localparam logic [1:0] MARK_X = 2'b01;
    localparam logic [1:0] MARK_O = 2'b10;

    localparam logic [10:0] X_LO  = 11'(BOARD_X);
    localparam logic [10:0] X_M1  = 11'(BOARD_X + CELL_W);
    localparam logic [10:0] X_M2  = 11'(BOARD_X + 2 * CELL_W);
    localparam logic [10:0] X_HI  = 11'(BOARD_X + 3 * CELL_W);
    localparam logic [10:0] Y_LO  = 11'(BOARD_Y);
    localparam logic [10:0] Y_M1  = 11'(BOARD_Y + CELL_H);
    localparam logic [10:0] Y_M2  = 11'(BOARD_Y + 2 * CELL_H);
    localparam logic [10:0] Y_HI  = 11'(BOARD_Y + 3 * CELL_H);
    localparam logic [9:0]  CX0   = 10'(BOARD_X);
    localparam logic [9:0]  CX1   = 10'(BOARD_X + CELL_W);
    localparam logic [9:0]  CX2   = 10'(BOARD_X + 2 * CELL_W);
    localparam logic [8:0]  CY0   = 9'(BOARD_Y);
    localparam logic [8:0]  CY1   = 9'(BOARD_Y + CELL_H);
    localparam logic [8:0]  CY2   = 9'(BOARD_Y + 2 * CELL_H);
    localparam logic [10:0] T_LO  = 11'(CUR_T);
    localparam logic [10:0] T_HIX = 11'(CELL_W - CUR_T);
    localparam logic [10:0] T_HIY = 11'(CELL_H - CUR_T);

    function automatic logic [3:0] cell_idx(input logic [1:0] r, input logic [1:0] c);
        return {1'b0, r, 1'b0} + {2'b00, r} + {2'b00, c};
    endfunction

    function automatic logic [1:0] wrap_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    function automatic logic [1:0] wrap_dec(input logic [1:0] v);
        return (v == 2'd0) ? 2'd2 : v - 2'd1;
    endfunction

    function automatic logic [1:0] line_mark(input logic [1:0] a, input logic [1:0] b,
                                             input logic [1:0] c);
        return (a != 2'b00 && a == b && b == c) ? a : 2'b00;
    endfunction

    state_t      state_q;
    logic [1:0]  board_q [9];
    logic [1:0]  cur_row_q, cur_col_q;
    logic        turn_q;
    logic [1:0]  winner_q;
    logic [7:0]  win_line_q;

    logic [5:0]  btn_now, btn_q, btn_rise;
    logic        ev_restart, ev_place, ev_up, ev_down, ev_left, ev_right;

    logic [1:0]  line_m [8];
    logic [7:0]  lines_hit;
    logic [1:0]  win_mark;
    logic        board_full;
    logic [3:0]  cur_idx;

    assign btn_now  = {btn_restart, btn_place, btn_up, btn_down, btn_left, btn_right};
    assign btn_rise = btn_now & ~btn_q;

    // Delayed copies reset high so a button held through reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) btn_q <= '1;
        else        btn_q <= btn_now;
    end

    always_comb begin
        ev_restart = btn_rise[5];
        ev_place   = btn_rise[4] & ~btn_rise[5];
        ev_up      = btn_rise[3] & ~|btn_rise[5:4];
        ev_down    = btn_rise[2] & ~|btn_rise[5:3];
        ev_left    = btn_rise[1] & ~|btn_rise[5:2];
        ev_right   = btn_rise[0] & ~|btn_rise[5:1];
    end

    always_comb begin
        line_m[0] = line_mark(board_q[0], board_q[1], board_q[2]);
        line_m[1] = line_mark(board_q[3], board_q[4], board_q[5]);
        line_m[2] = line_mark(board_q[6], board_q[7], board_q[8]);
        line_m[3] = line_mark(board_q[0], board_q[3], board_q[6]);
        line_m[4] = line_mark(board_q[1], board_q[4], board_q[7]);
        line_m[5] = line_mark(board_q[2], board_q[5], board_q[8]);
        line_m[6] = line_mark(board_q[0], board_q[4], board_q[8]);
        line_m[7] = line_mark(board_q[2], board_q[4], board_q[6]);
        lines_hit = 8'h00;
        win_mark  = 2'b00;
        for (int i = 0; i < 8; i++) begin
            lines_hit[i] = |line_m[i];
            win_mark     = win_mark | line_m[i];
        end
        board_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (board_q[i] == 2'b00) board_full = 1'b0;
        end
    end

    assign cur_idx = cell_idx(cur_row_q, cur_col_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_PLAY;
            for (int i = 0; i < 9; i++) board_q[i] <= 2'b00;
            cur_row_q  <= 2'd1;
            cur_col_q  <= 2'd1;
            turn_q     <= 1'b0;
            winner_q   <= 2'b00;
            win_line_q <= 8'h00;
        end else if (ev_restart) begin
            state_q    <= ST_PLAY;
            for (int i = 0; i < 9; i++) board_q[i] <= 2'b00;
            cur_row_q  <= 2'd1;
            cur_col_q  <= 2'd1;
            turn_q     <= 1'b0;
            winner_q   <= 2'b00;
            win_line_q <= 8'h00;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (ev_place) begin
                        if (board_q[cur_idx] == 2'b00) begin
                            board_q[cur_idx] <= turn_q ? MARK_O : MARK_X;
                            state_q          <= ST_CHECK;
                        end
                    end else if (ev_up) begin
                        cur_row_q <= wrap_dec(cur_row_q);
                    end else if (ev_down) begin
                        cur_row_q <= wrap_inc(cur_row_q);
                    end else if (ev_left) begin
                        cur_col_q <= wrap_dec(cur_col_q);
                    end else if (ev_right) begin
                        cur_col_q <= wrap_inc(cur_col_q);
                    end
                end
                ST_CHECK: begin
                    if (|lines_hit) begin
                        win_line_q <= lines_hit;
                        winner_q   <= win_mark;
                        state_q    <= ST_WIN;
                    end else if (board_full) begin
                        state_q    <= ST_DRAW;
                    end else begin
                        turn_q     <= ~turn_q;
                        state_q    <= ST_PLAY;
                    end
                end
                default: ;
            endcase
        end
    end

    assign turn       = turn_q;
    assign game_state = state_q;
    assign winner     = winner_q;
    assign win_line   = win_line_q;

    logic [10:0] sx, sy, dx, dy;
    logic [1:0]  col_d, row_d;
    logic [9:0]  cell_x_d, cell_x_q;
    logic [8:0]  cell_y_d, cell_y_q;
    logic [1:0]  cell_mark_d, cell_mark_q;
    logic        in_board_d, in_board_q;
    logic        cursor_hit_d, cursor_hit_q;

    // Cell lookup by threshold compares; dx/dy are only meaningful inside the board.
    always_comb begin
        sx = {1'b0, scan_x};
        sy = {2'b00, scan_y};
        if (sx < X_M1)      begin col_d = 2'd0; cell_x_d = CX0; end
        else if (sx < X_M2) begin col_d = 2'd1; cell_x_d = CX1; end
        else                begin col_d = 2'd2; cell_x_d = CX2; end
        if (sy < Y_M1)      begin row_d = 2'd0; cell_y_d = CY0; end
        else if (sy < Y_M2) begin row_d = 2'd1; cell_y_d = CY1; end
        else                begin row_d = 2'd2; cell_y_d = CY2; end
        in_board_d   = (sx >= X_LO) && (sx < X_HI) && (sy >= Y_LO) && (sy < Y_HI);
        dx           = sx - {1'b0, cell_x_d};
        dy           = sy - {2'b00, cell_y_d};
        cell_mark_d  = in_board_d ? board_q[cell_idx(row_d, col_d)] : 2'b00;
        cursor_hit_d = in_board_d && (row_d == cur_row_q) && (col_d == cur_col_q) &&
                       ((dx < T_LO) || (dx >= T_HIX) || (dy < T_LO) || (dy >= T_HIY));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_x_q     <= '0;
            cell_y_q     <= '0;
            cell_mark_q  <= '0;
            in_board_q   <= 1'b0;
            cursor_hit_q <= 1'b0;
        end else begin
            cell_x_q     <= cell_x_d;
            cell_y_q     <= cell_y_d;
            cell_mark_q  <= cell_mark_d;
            in_board_q   <= in_board_d;
            cursor_hit_q <= cursor_hit_d;
        end
    end

    assign cell_x     = cell_x_q;
    assign cell_y     = cell_y_q;
    assign cell_mark  = cell_mark_q;
    assign in_board   = in_board_q;
    assign cursor_hit = cursor_hit_q;

endmodule

// File: tb/tb_xo_board_ctrl.sv
// Self-checking bench for xo_board_ctrl: pixel-lookup vector table through a
// scoreboard queue, plus hand-written game sequences.
module tb_xo_board_ctrl;

    localparam int BX = 80, BY = 60, CW = 160, CH = 120;
    localparam logic [5:0] B_RST = 6'b100000, B_PLC = 6'b010000, B_UP = 6'b001000,
                           B_DN  = 6'b000100, B_LT  = 6'b000010, B_RT = 6'b000001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up, btn_down, btn_left, btn_right, btn_place, btn_restart;
    logic [9:0] scan_x;
    logic [8:0] scan_y;
    logic [9:0] cell_x;
    logic [8:0] cell_y;
    logic [1:0] cell_mark, game_state, winner;
    logic       in_board, cursor_hit, turn;
    logic [7:0] win_line;

    always #5 clk = ~clk;

    xo_board_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_place(btn_place), .btn_restart(btn_restart),
        .scan_x(scan_x), .scan_y(scan_y),
        .cell_x(cell_x), .cell_y(cell_y), .cell_mark(cell_mark),
        .in_board(in_board), .cursor_hit(cursor_hit), .turn(turn),
        .game_state(game_state), .winner(winner), .win_line(win_line)
    );

    typedef struct {
        int cx; int cy; int mark; int inb; int hit;
    } pix_t;

    typedef struct {
        int   sx; int sy; pix_t e;
    } vec_t;

    pix_t       sb_q[$];
    int         n_cmp = 0, n_err = 0;
    logic [1:0] board_m [9];
    int         cur_r, cur_c;
    logic       turn_m;
    vec_t       vecs [14];

    function automatic pix_t mkp(int cx, int cy, int mark, int inb, int hit);
        pix_t p;
        p.cx = cx; p.cy = cy; p.mark = mark; p.inb = inb; p.hit = hit;
        return p;
    endfunction

    function automatic vec_t mkv(int sx, int sy, int cx, int cy, int mark, int inb, int hit);
        vec_t v;
        v.sx = sx; v.sy = sy; v.e = mkp(cx, cy, mark, inb, hit);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [5:0] b);
        {btn_restart, btn_place, btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    task automatic press(input logic [5:0] b);
        set_btn(b);
        tick();
        set_btn(6'b0);
        tick();
    endtask

    task automatic scan(input string name, input int sx, input int sy, input pix_t e);
        pix_t w;
        scan_x = 10'(sx);
        scan_y = 9'(sy);
        sb_q.push_back(e);
        tick();
        if (sb_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            w = sb_q.pop_front();
            chk({name, ".cell_x"}, int'(cell_x), w.cx);
            chk({name, ".cell_y"}, int'(cell_y), w.cy);
            chk({name, ".cell_mark"}, int'(cell_mark), w.mark);
            chk({name, ".in_board"}, int'(in_board), w.inb);
            chk({name, ".cursor_hit"}, int'(cursor_hit), w.hit);
        end
    endtask

    task automatic check_cell(input string name, input int r, input int c);
        scan(name, BX + c * CW + CW / 2, BY + r * CH + CH / 2,
             mkp(BX + c * CW, BY + r * CH, int'(board_m[r * 3 + c]), 1, 0));
    endtask

    task automatic check_cursor(input string name, input int r, input int c);
        scan(name, BX + c * CW, BY + r * CH + CH / 2,
             mkp(BX + c * CW, BY + r * CH, int'(board_m[r * 3 + c]), 1, 1));
    endtask

    task automatic check_board(input string name);
        for (int i = 0; i < 9; i++) check_cell($sformatf("%s[%0d]", name, i), i / 3, i % 3);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 9; i++) board_m[i] = 2'b00;
        cur_r = 1; cur_c = 1; turn_m = 1'b0;
    endtask

    task automatic goto_cell(input int r, input int c);
        while (cur_c != c) begin press(B_RT); cur_c = (cur_c == 2) ? 0 : cur_c + 1; end
        while (cur_r != r) begin press(B_DN); cur_r = (cur_r == 2) ? 0 : cur_r + 1; end
    endtask

    task automatic place_at(input int r, input int c);
        goto_cell(r, c);
        press(B_PLC);
        board_m[r * 3 + c] = turn_m ? 2'b10 : 2'b01;
        turn_m = ~turn_m;
    endtask

    int ord [9];

    initial begin
        set_btn(6'b0);
        scan_x = 10'd320;
        scan_y = 9'd240;
        reset_model();
        repeat (3) tick();
        chk("rst.game_state", int'(game_state), 0);
        chk("rst.turn", int'(turn), 0);
        chk("rst.winner", int'(winner), 0);
        chk("rst.win_line", int'(win_line), 0);
        chk("rst.cell_x", int'(cell_x), 0);
        chk("rst.cell_y", int'(cell_y), 0);
        chk("rst.cell_mark", int'(cell_mark), 0);
        chk("rst.in_board", int'(in_board), 0);
        chk("rst.cursor_hit", int'(cursor_hit), 0);
        rst_n = 1'b1;
        tick();

        // Empty board, cursor at (1,1).
        vecs[0]  = mkv(80,   60,  80,  60,  0, 1, 0);
        vecs[1]  = mkv(79,   60,  80,  60,  0, 0, 0);
        vecs[2]  = mkv(240,  180, 240, 180, 0, 1, 1);
        vecs[3]  = mkv(242,  250, 240, 180, 0, 1, 1);
        vecs[4]  = mkv(243,  250, 240, 180, 0, 1, 0);
        vecs[5]  = mkv(397,  250, 240, 180, 0, 1, 1);
        vecs[6]  = mkv(396,  250, 240, 180, 0, 1, 0);
        vecs[7]  = mkv(300,  299, 240, 180, 0, 1, 1);
        vecs[8]  = mkv(300,  296, 240, 180, 0, 1, 0);
        vecs[9]  = mkv(559,  419, 400, 300, 0, 1, 0);
        vecs[10] = mkv(560,  419, 400, 300, 0, 0, 0);
        vecs[11] = mkv(300,  420, 240, 300, 0, 0, 0);
        vecs[12] = mkv(300,  59,  240, 60,  0, 0, 0);
        vecs[13] = mkv(1023, 511, 400, 300, 0, 0, 0);
        for (int i = 0; i < 14; i++) scan($sformatf("vec%0d", i), vecs[i].sx, vecs[i].sy, vecs[i].e);

        // First place at centre: CHECK for exactly one cycle, then O to move.
        set_btn(B_PLC);
        tick();
        chk("first.check_state", int'(game_state), 1);
        set_btn(6'b0);
        board_m[4] = 2'b01;
        check_cell("first.cell4", 1, 1);
        chk("first.play_state", int'(game_state), 0);
        chk("first.turn", int'(turn), 1);
        press(B_RST);
        reset_model();
        chk("rst1.turn", int'(turn), 0);
        check_cell("rst1.cell4", 1, 1);

        // Cursor wrapping and event priority.
        press(B_LT); press(B_LT); cur_c = 2;
        check_cursor("wrap_left", 1, 2);
        press(B_UP); press(B_UP); cur_r = 2;
        check_cursor("wrap_up", 2, 2);
        press(B_RT); press(B_DN); cur_r = 0; cur_c = 0;
        check_cursor("wrap_rt_dn", 0, 0);
        press(B_DN | B_LT); cur_r = 1;
        check_cursor("prio_dn_lt", 1, 0);
        press(B_PLC | B_UP);
        board_m[3] = 2'b01;
        check_cursor("prio_plc_up", 1, 0);
        chk("prio_plc_up.state", int'(game_state), 0);
        chk("prio_plc_up.turn", int'(turn), 1);
        set_btn(B_PLC);
        tick();
        chk("occupied.state", int'(game_state), 0);
        set_btn(6'b0);
        tick();
        chk("occupied.turn", int'(turn), 1);
        press(B_RST | B_PLC | B_UP);
        reset_model();
        check_cursor("prio_rst.cursor", 1, 1);
        check_cell("prio_rst.cell3", 1, 0);
        chk("prio_rst.turn", int'(turn), 0);

        // X completes row 0.
        place_at(0, 0);
        chk("win.turn_after_x", int'(turn), 1);
        place_at(1, 0);
        place_at(0, 1);
        place_at(1, 1);
        place_at(0, 2);
        chk("win.state", int'(game_state), 2);
        chk("win.winner", int'(winner), 1);
        chk("win.win_line", int'(win_line), 8'h01);
        chk("win.turn", int'(turn), 0);
        press(B_DN); press(B_PLC); press(B_LT); press(B_UP);
        check_board("win.board");
        check_cursor("win.cursor", 0, 2);
        chk("win.state_hold", int'(game_state), 2);
        press(B_RST);
        reset_model();

        // Draw: X 0,2,3,7,8 / O 1,4,5,6.
        ord = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        for (int k = 0; k < 9; k++) begin
            place_at(ord[k] / 3, ord[k] % 3);
            if (k < 8) chk($sformatf("draw.mid%0d", k), int'(game_state), 0);
        end
        chk("draw.state", int'(game_state), 3);
        chk("draw.winner", int'(winner), 0);
        chk("draw.win_line", int'(win_line), 0);
        check_board("draw.board");
        press(B_RST);
        reset_model();
        check_board("draw_rst.board");
        check_cursor("draw_rst.cursor", 1, 1);
        chk("draw_rst.turn", int'(turn), 0);
        chk("draw_rst.state", int'(game_state), 0);

        // Cursor border just inside the bottom cell, plus off-board left.
        press(B_DN); cur_r = 2;
        scan("border", BX + CW, BY + 2 * CH + 1, mkp(240, 300, 0, 1, 1));
        scan("off_left", BX - 1, BY + 2 * CH + 1, mkp(80, 300, 0, 0, 0));

        // Restart taken while in CHECK.
        set_btn(B_PLC);
        tick();
        chk("rst_in_check.check", int'(game_state), 1);
        set_btn(B_PLC | B_RST);
        tick();
        chk("rst_in_check.state", int'(game_state), 0);
        chk("rst_in_check.turn", int'(turn), 0);
        set_btn(6'b0);
        tick();
        reset_model();
        check_cell("rst_in_check.cell7", 2, 1);

        // Reset asserted mid-CHECK.
        set_btn(B_PLC);
        tick();
        chk("hw_rst_check.check", int'(game_state), 1);
        rst_n = 1'b0;
        #1;
        chk("hw_rst_check.state", int'(game_state), 0);
        chk("hw_rst_check.turn", int'(turn), 0);
        set_btn(6'b0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check_cell("hw_rst_check.cell4", 1, 1);
        chk("hw_rst_check.turn2", int'(turn), 0);

        // Place held through reset release is not an event.
        set_btn(B_PLC);
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("held.state", int'(game_state), 0);
        check_cell("held.cell4", 1, 1);
        set_btn(6'b0);
        tick();
        press(B_PLC);
        board_m[4] = 2'b01;
        check_cell("held.cell4_after", 1, 1);
        chk("held.turn", int'(turn), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
